// File: rtl/rect_pkg.sv
// Shared types and defaults for the rectangle fill engine and the blitters
// that reuse its raster walker. Defaults match the 160x120, 12-bit colour
// framebuffer.
package rect_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam int RECT_X_W     = 8;
    localparam int RECT_Y_W     = 7;
    localparam int RECT_COLOR_W = 12;

    localparam logic [11:0] COLOR_WHITE = 12'hfff;

endpackage

// File: rtl/raster_walker.sv
// Raster-order coordinate stepper. On i_load it captures the start corner and
// the exclusive far corner (stored as inclusive x1-1 / y1-1) and places the
// cursor at (x0,y0). Each i_advance moves the cursor one pixel in row-major
// order; on the final pixel the cursor holds and o_last stays high.
// With i_skip_interior set, interior rows only visit x0 and x1-1.
module raster_walker
    import rect_pkg::*;
#(
    parameter int X_W = RECT_X_W,
    parameter int Y_W = RECT_Y_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_load,
    input  logic [X_W-1:0] i_x0,
    input  logic [Y_W-1:0] i_y0,
    input  logic [X_W-1:0] i_x1,
    input  logic [Y_W-1:0] i_y1,
    input  logic           i_skip_interior,
    input  logic           i_advance,
    output logic [X_W-1:0] o_sx,
    output logic [Y_W-1:0] o_sy,
    output logic           o_last
);

    localparam logic [X_W-1:0] X_ONE = {{(X_W-1){1'b0}}, 1'b1};
    localparam logic [Y_W-1:0] Y_ONE = {{(Y_W-1){1'b0}}, 1'b1};

    logic [X_W-1:0] r_x0;
    logic [Y_W-1:0] r_y0;
    logic [X_W-1:0] r_x1m1;
    logic [Y_W-1:0] r_y1m1;
    logic [X_W-1:0] r_sx;
    logic [Y_W-1:0] r_sy;

    logic           w_x_end;
    logic           w_y_end;
    logic           w_last;
    logic           w_interior;
    logic           w_jump;
    logic [X_W-1:0] w_nx;
    logic [Y_W-1:0] w_ny;

    // Next cursor position: wrap to x0 on the row end, jump across interior
    // rows in outline mode, otherwise step right. Bounds are compared within
    // the coordinate width so x1/y1 at the width maximum never wrap.
    always_comb begin
        w_x_end    = (r_sx == r_x1m1);
        w_y_end    = (r_sy == r_y1m1);
        w_last     = w_x_end && w_y_end;
        w_interior = (r_sy != r_y0) && !w_y_end;
        w_jump     = i_skip_interior && w_interior &&
                     (r_sx == r_x0) && (r_x1m1 > r_x0);
        w_nx       = r_sx + X_ONE;
        w_ny       = r_sy;
        if (w_x_end) begin
            w_nx = r_x0;
            w_ny = r_sy + Y_ONE;
        end else if (w_jump) begin
            w_nx = r_x1m1;
            w_ny = r_sy;
        end else begin
            w_nx = r_sx + X_ONE;
            w_ny = r_sy;
        end
    end

    // Bounds capture on load, cursor update on each accepted advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x0   <= {X_W{1'b0}};
            r_y0   <= {Y_W{1'b0}};
            r_x1m1 <= {X_W{1'b0}};
            r_y1m1 <= {Y_W{1'b0}};
            r_sx   <= {X_W{1'b0}};
            r_sy   <= {Y_W{1'b0}};
        end else if (i_load) begin
            r_x0   <= i_x0;
            r_y0   <= i_y0;
            r_x1m1 <= i_x1 - X_ONE;
            r_y1m1 <= i_y1 - Y_ONE;
            r_sx   <= i_x0;
            r_sy   <= i_y0;
        end else if (i_advance && !w_last) begin
            r_sx   <= w_nx;
            r_sy   <= w_ny;
        end else begin
            r_sx   <= r_sx;
            r_sy   <= r_sy;
        end
    end

    assign o_sx   = r_sx;
    assign o_sy   = r_sy;
    assign o_last = w_last;

endmodule

// File: rtl/rect_fill.sv
// Rectangle fill engine: accepts a rectangle command (corners + colour) and
// streams one pixel per accepted beat over a valid/ready interface in raster
// order. Degenerate rectangles (x0>=x1 or y0>=y1) produce no pixels but still
// report busy and a done pulse.
// Optional build macro RECT_FILL_OUTLINE_EN: when defined, a command latched
// with outline=1 emits only border pixels. When undefined the outline input
// is ignored and no outline logic exists.
module rect_fill
    import rect_pkg::*;
#(
    parameter int X_W     = RECT_X_W,
    parameter int Y_W     = RECT_Y_W,
    parameter int COLOR_W = RECT_COLOR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [X_W-1:0]     x0,
    input  logic [Y_W-1:0]     y0,
    input  logic [X_W-1:0]     x1,
    input  logic [Y_W-1:0]     y1,
    input  logic [COLOR_W-1:0] fill,
    input  logic               outline,
    output logic               busy,
    output logic               done,
    output logic               px_valid,
    input  logic               px_ready,
    output logic [X_W-1:0]     sx,
    output logic [Y_W-1:0]     sy,
    output logic [COLOR_W-1:0] color
);

    state_t             r_state;
    logic               r_busy;
    logic               r_done;
    logic               r_px_valid;
    logic [COLOR_W-1:0] r_color;

    logic               w_accept;
    logic               w_degenerate;
    logic               w_beat;
    logic               w_last;
    logic               w_skip;

`ifdef RECT_FILL_OUTLINE_EN
    logic               r_outline;

    // Outline request is captured with the geometry and held for the command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outline <= 1'b0;
        end else if (w_accept) begin
            r_outline <= outline;
        end else begin
            r_outline <= r_outline;
        end
    end

    assign w_skip = r_outline;
`else
    logic               w_unused;

    assign w_unused = outline;
    assign w_skip   = 1'b0;
`endif

    assign w_accept     = (r_state == IDLE) && start;
    assign w_degenerate = (x0 >= x1) || (y0 >= y1);
    assign w_beat       = r_px_valid && px_ready;

    raster_walker #(
        .X_W (X_W),
        .Y_W (Y_W)
    ) u_walker (
        .clk             (clk),
        .rst             (rst),
        .i_load          (w_accept),
        .i_x0            (x0),
        .i_y0            (y0),
        .i_x1            (x1),
        .i_y1            (y1),
        .i_skip_interior (w_skip),
        .i_advance       (w_beat),
        .o_sx            (sx),
        .o_sy            (sy),
        .o_last          (w_last)
    );

    // Command FSM: accepts start in IDLE, streams beats in DRAW and issues the
    // single-cycle done pulse in FIN. A degenerate command spends one busy
    // cycle in FIN before its done cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_px_valid <= 1'b0;
            r_color    <= {COLOR_W{1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_color <= fill;
                        r_busy  <= 1'b1;
                        if (w_degenerate) begin
                            r_state    <= FIN;
                            r_px_valid <= 1'b0;
                        end else begin
                            r_state    <= DRAW;
                            r_px_valid <= 1'b1;
                        end
                    end else begin
                        r_state    <= IDLE;
                        r_busy     <= 1'b0;
                        r_px_valid <= 1'b0;
                    end
                end
                DRAW: begin
                    if (w_beat && w_last) begin
                        r_state    <= FIN;
                        r_px_valid <= 1'b0;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                    end else begin
                        r_state    <= DRAW;
                        r_px_valid <= 1'b1;
                    end
                end
                FIN: begin
                    r_px_valid <= 1'b0;
                    if (r_done) begin
                        r_done  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= FIN;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                    r_px_valid <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign px_valid = r_px_valid;
    assign color    = r_color;

endmodule

// File: tb/tb_rect_fill.sv
// Scoreboard bench for rect_fill: each command pushes its expected pixel
// stream into a queue; a negedge monitor pops and compares on every accepted
// beat and checks that stalled beats hold stable.
module tb_rect_fill;
    import rect_pkg::*;

    localparam int LIMIT = 20000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  x0, x1;
    logic [6:0]  y0, y1;
    logic [11:0] fill;
    logic        outline;
    logic        busy, done, px_valid, px_ready;
    logic [7:0]  sx;
    logic [6:0]  sy;
    logic [11:0] color;

    logic [26:0] exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          beat_cnt = 0;
    int          done_cnt = 0;
    int          last_beat_cyc = 0;
    bit          ready_rand = 1'b0;
    bit          stalled_prev = 1'b0;
    logic [27:0] prev_out;

    rect_fill dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .x0       (x0),
        .y0       (y0),
        .x1       (x1),
        .y1       (y1),
        .fill     (fill),
        .outline  (outline),
        .busy     (busy),
        .done     (done),
        .px_valid (px_valid),
        .px_ready (px_ready),
        .sx       (sx),
        .sy       (sy),
        .color    (color)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Downstream ready: held high or toggled randomly
    initial begin
        px_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            px_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: compare every accepted beat against the scoreboard
    always @(negedge clk) begin
        if (rst !== 1'b0) begin
            stalled_prev = 1'b0;
        end else begin
            if (stalled_prev)
                chk("stall_hold", {4'd0, px_valid, sx, sy, color}, {4'd0, prev_out});
            if (px_valid && px_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", {5'd0, sx, sy, color}, 32'hffffffff);
                end else begin
                    chk("beat", {5'd0, sx, sy, color}, {5'd0, exp_q.pop_front()});
                end
                beat_cnt++;
                last_beat_cyc = cyc;
            end
            stalled_prev = px_valid && !px_ready;
            prev_out = {px_valid, sx, sy, color};
            if (done) done_cnt++;
        end
    end

    task automatic push_expected(input int ax0, input int ay0, input int ax1, input int ay1,
                                 input logic [11:0] f, input logic ol);
        logic [7:0] xs;
        logic [6:0] ys;
        bit keep;
        for (int y = ay0; y < ay1; y++) begin
            for (int x = ax0; x < ax1; x++) begin
                keep = 1'b1;
`ifdef RECT_FILL_OUTLINE_EN
                if (ol) keep = (x == ax0) || (x == ax1 - 1) || (y == ay0) || (y == ay1 - 1);
`else
                keep = keep | ol;
`endif
                xs = x[7:0];
                ys = y[6:0];
                if (keep) exp_q.push_back({xs, ys, f});
            end
        end
    endtask

    task automatic run_cmd(input int ax0, input int ay0, input int ax1, input int ay1,
                           input logic [11:0] f, input logic ol, input bit rnd,
                           input int stray_at, input int hand_cnt);
        int n;
        int b0;
        int d0;
        push_expected(ax0, ay0, ax1, ay1, f, ol);
        ready_rand = rnd;
        b0 = beat_cnt;
        d0 = done_cnt;
        @(posedge clk);
        #1;
        x0 = ax0[7:0]; y0 = ay0[6:0]; x1 = ax1[7:0]; y1 = ay1[6:0];
        fill = f; outline = ol; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        x0 = 8'($urandom); y0 = 7'($urandom); x1 = 8'($urandom); y1 = 7'($urandom);
        fill = 12'($urandom); outline = ~ol;
        @(negedge clk);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        n = 0;
        while (done !== 1'b1 && n < LIMIT) begin
            @(negedge clk);
            n++;
            if (n == stray_at) begin
                x0 = 8'd0; y0 = 7'd0; x1 = 8'd2; y1 = 7'd2; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (n >= LIMIT) begin
            chk("done_timeout", 32'(n), 32'(LIMIT - 1));
        end else begin
            chk("busy_at_done", {31'd0, busy}, 32'd0);
            chk("valid_at_done", {31'd0, px_valid}, 32'd0);
            chk("queue_drained", 32'(exp_q.size()), 32'd0);
            chk("beat_count", 32'(beat_cnt - b0), 32'(hand_cnt));
            if (hand_cnt == 0)
                chk("degen_done_latency", 32'(n), 32'd1);
            else
                chk("done_after_last", 32'(cyc - last_beat_cyc), 32'd1);
        end
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("done_pulses", 32'(done_cnt - d0), 32'd1);
        exp_q.delete();
        ready_rand = 1'b0;
    endtask

    task automatic reset_mid_draw();
        int d0;
        push_expected(0, 0, 160, 100, 12'h00f, 1'b0);
        ready_rand = 1'b0;
        @(posedge clk);
        #1;
        x0 = 8'd0; y0 = 7'd0; x1 = 8'd160; y1 = 7'd100; fill = 12'h00f; outline = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(negedge clk);
        chk("valid_before_reset", {31'd0, px_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_valid", {31'd0, px_valid}, 32'd0);
        chk("rst_async_busy", {31'd0, busy}, 32'd0);
        exp_q.delete();
        d0 = done_cnt;
        @(negedge clk);
        #2;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("no_done_after_reset", 32'(done_cnt - d0), 32'd0);
        chk("idle_after_reset", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        x0 = 8'd0; y0 = 7'd0; x1 = 8'd0; y1 = 7'd0;
        fill = 12'd0; outline = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_valid", {31'd0, px_valid}, 32'd0);
        chk("reset_sx", {24'd0, sx}, 32'd0);
        chk("reset_sy", {25'd0, sy}, 32'd0);
        chk("reset_color", {20'd0, color}, 32'd0);
        #2;
        rst = 1'b0;

        reset_mid_draw();
        // Basic fill
        run_cmd(10, 25, 100, 55, COLOR_WHITE, 1'b0, 1'b0, -1, 2700);
        // Backpressure
        run_cmd(0, 0, 3, 2, 12'h0a5, 1'b0, 1'b1, -1, 6);
        // Degenerate
        run_cmd(5, 3, 5, 40, 12'h111, 1'b0, 1'b0, -1, 0);
        run_cmd(1, 9, 20, 3, 12'h222, 1'b0, 1'b0, -1, 0);
        // Edge bounds with a stray start during DRAW
        run_cmd(150, 110, 255, 127, 12'h123, 1'b0, 1'b0, 30, 1785);
        // Outline request: border only when the feature is built in
`ifdef RECT_FILL_OUTLINE_EN
        run_cmd(2, 2, 6, 5, 12'h0f0, 1'b1, 1'b0, -1, 10);
        run_cmd(2, 2, 6, 5, 12'h0f0, 1'b1, 1'b1, -1, 10);
        run_cmd(4, 1, 5, 6, 12'h321, 1'b1, 1'b0, -1, 5);
`else
        run_cmd(2, 2, 6, 5, 12'h0f0, 1'b1, 1'b0, -1, 12);
`endif
        run_cmd(2, 2, 6, 5, 12'h0f0, 1'b0, 1'b1, -1, 12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
